// File: rtl/pc_gen_pkg.sv
// Shared next-PC mode encodings and constants
// for the program-counter generator.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_BR   = 3'd1,
        PC_JAL  = 3'd2,
        PC_JALR = 3'd3,
        PC_RET  = 3'd4
    } pc_src_e;

    localparam int ILEN_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Control/ALU side bundle of the PC generator:
// the master drives next-PC controls, the slave returns PC state.
interface pc_gen_if #(
    parameter int XLEN = 32
) ();

    logic            pc_load;
    logic [2:0]      pc_src;
    logic            br_taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] y;
    logic            is_call;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            misalign;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output pc_load, pc_src, br_taken, imm, y,
        output is_call, trap_req, trap_vec,
        input  pc, npc, misalign, ras_empty, ras_full
    );

    modport slave (
        input  pc_load, pc_src, br_taken, imm, y,
        input  is_call, trap_req, trap_vec,
        output pc, npc, misalign, ras_empty, ras_full
    );

endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack; a push while full
// overwrites the oldest entry, a pop while empty is ignored.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   ptr_inc;

    assign ptr_inc = ptr + PW'(1);
    assign top     = mem[ptr];
    assign empty   = (count == '0);
    assign full    = (count == CMAX);

    // ptr always indexes the most recent entry
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            mem[ptr_inc] <= wdata;
            ptr          <= ptr_inc;
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: next-PC select with trap
// redirection and return prediction from a RAS.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic    clk,
    input logic    rst,
    pc_gen_if.slave bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] jr;
    logic [XLEN-1:0] nxt;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            commit;
    logic            push;
    logic            pop;

    assign seq = pc_q + XLEN'(ILEN_BYTES);
    assign tgt = pc_q + bus.imm;
    assign jr  = {bus.y[XLEN-1:1], 1'b0};

    always_comb begin
        nxt = seq;
        if (bus.trap_req) begin
            nxt = bus.trap_vec;
        end else begin
            case (bus.pc_src)
                PC_BR:   nxt = bus.br_taken ? tgt : seq;
                PC_JAL:  nxt = tgt;
                PC_JALR: nxt = jr;
                PC_RET:  nxt = ras_empty ? jr : ras_top;
                default: nxt = seq;
            endcase
        end
    end

    assign commit = bus.pc_load && !bus.trap_req;
    assign push   = commit && bus.is_call &&
                    (bus.pc_src == PC_JAL || bus.pc_src == PC_JALR);
    assign pop    = commit && (bus.pc_src == PC_RET) && !ras_empty;

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else if (bus.trap_req || bus.pc_load)
            pc_q <= nxt;
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign bus.pc        = pc_q;
    assign bus.npc       = nxt;
    assign bus.misalign  = !bus.trap_req && (nxt[1:0] != 2'b00);
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, branch, jalr,
// call/return, RAS overflow and trap priority.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0000_1000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_PC  (RPC),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        bus.trap_req = 1'b1;
        bus.trap_vec = v;
        step();
        bus.trap_req = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] ret_exp [5];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.pc_load  = 1'b0;
        bus.pc_src   = PC_SEQ;
        bus.br_taken = 1'b0;
        bus.imm      = '0;
        bus.y        = '0;
        bus.is_call  = 1'b0;
        bus.trap_req = 1'b0;
        bus.trap_vec = '0;

        // reset and sequential fetch
        step();
        step();
        chk("rst_pc", 64'(bus.pc), 64'h1000);
        chk("rst_empty", 64'(bus.ras_empty), 64'd1);
        chk("rst_full", 64'(bus.ras_full), 64'd0);
        rst = 1'b0;
        bus.pc_load = 1'b1;
        #1;
        chk("seq_npc", 64'(bus.npc), 64'h1004);
        step();
        chk("seq_pc1", 64'(bus.pc), 64'h1004);
        step();
        chk("seq_pc2", 64'(bus.pc), 64'h1008);
        chk("seq_empty", 64'(bus.ras_empty), 64'd1);
        bus.pc_src = 3'd6;
        #1;
        chk("src6_npc", 64'(bus.npc), 64'h100c);

        // branch
        set_pc(32'h100);
        chk("set_pc", 64'(bus.pc), 64'h100);
        bus.pc_src   = PC_BR;
        bus.br_taken = 1'b1;
        bus.imm      = 32'hFFFF_FFF8;
        bus.pc_load  = 1'b0;
        step();
        chk("br_hold", 64'(bus.pc), 64'h100);
        bus.pc_load = 1'b1;
        step();
        chk("br_taken", 64'(bus.pc), 64'hF8);
        set_pc(32'h100);
        bus.br_taken = 1'b0;
        step();
        chk("br_ntaken", 64'(bus.pc), 64'h104);

        // jalr
        bus.pc_src = PC_JALR;
        bus.y      = 32'h203;
        #1;
        chk("jalr_npc", 64'(bus.npc), 64'h202);
        chk("jalr_mis", 64'(bus.misalign), 64'd1);
        step();
        chk("jalr_pc", 64'(bus.pc), 64'h202);
        bus.y = 32'h2001;
        #1;
        chk("jalr_npc2", 64'(bus.npc), 64'h2000);
        chk("jalr_mis2", 64'(bus.misalign), 64'd0);

        // call / return
        set_pc(32'h40);
        bus.pc_src  = PC_JAL;
        bus.is_call = 1'b1;
        bus.imm     = 32'h100;
        step();
        chk("call_pc", 64'(bus.pc), 64'h140);
        chk("call_nempty", 64'(bus.ras_empty), 64'd0);
        bus.is_call = 1'b0;
        bus.pc_src  = PC_RET;
        bus.y       = 32'h0;
        #1;
        chk("ret_npc", 64'(bus.npc), 64'h44);
        step();
        chk("ret_pc", 64'(bus.pc), 64'h44);
        chk("ret_empty", 64'(bus.ras_empty), 64'd1);
        bus.y = 32'h80;
        step();
        chk("ret_fallback", 64'(bus.pc), 64'h80);

        // RAS overflow
        bus.imm = '0;
        for (int i = 0; i < 5; i++) begin
            set_pc(32'(i * 16));
            bus.pc_src  = PC_JAL;
            bus.is_call = 1'b1;
            step();
            if (i == 3)
                chk("full_4th", 64'(bus.ras_full), 64'd1);
            if (i == 2)
                chk("nfull_3rd", 64'(bus.ras_full), 64'd0);
        end
        chk("full_5th", 64'(bus.ras_full), 64'd1);
        ret_exp[0] = 32'h44;
        ret_exp[1] = 32'h34;
        ret_exp[2] = 32'h24;
        ret_exp[3] = 32'h14;
        ret_exp[4] = 32'h998;
        bus.is_call = 1'b0;
        bus.pc_src  = PC_RET;
        bus.y       = 32'h999;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ovf_ret%0d", i), 64'(bus.pc), 64'(ret_exp[i]));
        end
        chk("ovf_empty", 64'(bus.ras_empty), 64'd1);

        // wrap-around of pc+4
        set_pc(32'hFFFF_FFFC);
        bus.pc_src = PC_SEQ;
        #1;
        chk("seq_wrap", 64'(bus.npc), 64'h0);

        // trap priority
        bus.pc_load  = 1'b0;
        bus.trap_req = 1'b1;
        bus.trap_vec = 32'h8000;
        #1;
        chk("trap_npc", 64'(bus.npc), 64'h8000);
        step();
        chk("trap_pc", 64'(bus.pc), 64'h8000);
        bus.pc_load  = 1'b1;
        bus.pc_src   = PC_JAL;
        bus.is_call  = 1'b1;
        bus.imm      = 32'h40;
        bus.trap_vec = 32'h9000;
        step();
        chk("trap_call_pc", 64'(bus.pc), 64'h9000);
        chk("trap_nopush", 64'(bus.ras_empty), 64'd1);
        bus.trap_req = 1'b0;
        bus.is_call  = 1'b0;
        bus.pc_src   = PC_RET;
        bus.y        = 32'h500;
        #1;
        chk("trap_ret_npc", 64'(bus.npc), 64'h500);
        rst          = 1'b1;
        bus.trap_req = 1'b1;
        step();
        chk("rst_trap_pc", 64'(bus.pc), 64'h1000);
        rst          = 1'b0;
        bus.trap_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
